// File: rtl/srl_var_delay_if.sv
//------------------------------------------------------------------------------
// Module   : srl_var_delay_if
// Brief    : Control/data bundle for the programmable delay line.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface srl_var_delay_if #(
   parameter int SRL_WIDTH     = 18,
   parameter int SRL_MAX_DEPTH = 32
);
   localparam int DW = $clog2(SRL_MAX_DEPTH + 1);

   logic                 en;
   logic                 flush;
   logic [DW-1:0]        delay;
   logic [SRL_WIDTH-1:0] din;
   logic                 din_valid;
   logic [SRL_WIDTH-1:0] dout;
   logic                 dout_valid;
   logic                 primed;

   modport master (
      output en, flush, delay, din, din_valid,
      input  dout, dout_valid, primed
   );

   modport slave (
      input  en, flush, delay, din, din_valid,
      output dout, dout_valid, primed
   );
endinterface

`default_nettype wire

// File: rtl/srl_var_delay.sv
//------------------------------------------------------------------------------
// Module   : srl_var_delay
// Brief    : Run-time selectable delay line with valid shadow and fill status.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module srl_var_delay #(
   parameter int SRL_WIDTH     = 18,
   parameter int SRL_MAX_DEPTH = 32
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   srl_var_delay_if.slave  bus
);
   localparam int DW = $clog2(SRL_MAX_DEPTH + 1);
   localparam int IW = (SRL_MAX_DEPTH > 1) ? $clog2(SRL_MAX_DEPTH) : 1;

   logic [SRL_WIDTH-1:0]     stage_q [SRL_MAX_DEPTH];
   logic [SRL_WIDTH-1:0]     stage_d [SRL_MAX_DEPTH];
   logic [SRL_MAX_DEPTH-1:0] vld_q;
   logic [SRL_MAX_DEPTH-1:0] vld_d;
   logic [DW-1:0]            fill_cnt_q;
   logic [DW-1:0]            fill_cnt_d;
   logic [DW-1:0]            eff_delay;
   logic [IW-1:0]            tap_idx;
   logic                     shift;

   assign shift = bus.en && !bus.flush;

   always_comb begin
      eff_delay = bus.delay;
      if (bus.delay == '0) begin
         eff_delay = DW'(1);
      end else if (bus.delay > DW'(SRL_MAX_DEPTH)) begin
         eff_delay = DW'(SRL_MAX_DEPTH);
      end
   end

   assign tap_idx = IW'(eff_delay - DW'(1));

   always_comb begin
      stage_d    = stage_q;
      vld_d      = vld_q;
      fill_cnt_d = fill_cnt_q;
      // Flush clears tracking only; data words stay where they are.
      if (bus.flush) begin
         vld_d      = '0;
         fill_cnt_d = '0;
      end else if (shift) begin
         stage_d[0] = bus.din;
         for (int i = 1; i < SRL_MAX_DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
         vld_d = {vld_q[SRL_MAX_DEPTH-2:0], bus.din_valid};
         if (fill_cnt_q != DW'(SRL_MAX_DEPTH)) begin
            fill_cnt_d = fill_cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SRL_MAX_DEPTH; i++) begin
            stage_q[i] <= '0;
         end
         vld_q      <= '0;
         fill_cnt_q <= '0;
      end else begin
         stage_q    <= stage_d;
         vld_q      <= vld_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   assign bus.dout       = stage_q[tap_idx];
   assign bus.dout_valid = vld_q[tap_idx];
   assign bus.primed     = (fill_cnt_q >= eff_delay);

endmodule

`default_nettype wire

// File: tb/tb_srl_var_delay.sv
//------------------------------------------------------------------------------
// Module   : tb_srl_var_delay
// Brief    : Directed and random checks of srl_var_delay against a history model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_srl_var_delay;
   localparam int W   = 18;
   localparam int MAX = 32;
   localparam int DW  = $clog2(MAX + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   srl_var_delay_if #(.SRL_WIDTH(W), .SRL_MAX_DEPTH(MAX)) bus ();

   srl_var_delay #(.SRL_WIDTH(W), .SRL_MAX_DEPTH(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: newest-first history of every word shifted in, plus a fill count.
   logic [W-1:0] m_data [$];
   bit           m_vld  [$];
   int           m_fill;

   function automatic int eff(input int d);
      if (d == 0)  return 1;
      if (d > MAX) return MAX;
      return d;
   endfunction

   task automatic m_reset();
      m_data.delete();
      m_vld.delete();
      for (int i = 0; i < MAX; i++) begin
         m_data.push_back('0);
         m_vld.push_back(1'b0);
      end
      m_fill = 0;
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag);
      int e;
      e = eff(int'(bus.delay));
      cmp({tag, "_dout"},   32'(bus.dout),       32'(m_data[e-1]));
      cmp({tag, "_vld"},    32'(bus.dout_valid), 32'(m_vld[e-1]));
      cmp({tag, "_primed"}, 32'(bus.primed),     32'(m_fill >= e));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst_n) begin
         if (bus.flush) begin
            foreach (m_vld[i]) m_vld[i] = 1'b0;
            m_fill = 0;
         end else if (bus.en) begin
            m_data.push_front(bus.din);
            m_vld.push_front(bus.din_valid);
            void'(m_data.pop_back());
            void'(m_vld.pop_back());
            if (m_fill < MAX) m_fill++;
         end
      end
      #1;
      chk(tag);
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      tick("flush");
      bus.flush = 1'b0;
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      cmp("arst_dout",   32'(bus.dout),       32'd0);
      cmp("arst_vld",    32'(bus.dout_valid), 32'd0);
      cmp("arst_primed", 32'(bus.primed),     32'd0);
      chk("arst");
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.flush     = 1'b0;
      bus.delay     = DW'(5);
      bus.din       = '0;
      bus.din_valid = 1'b0;

      // Reset, then a counting stream at delay 5
      #2 rst_n = 1'b0;
      m_reset();
      #1 chk("reset");
      #4 rst_n = 1'b1;
      bus.en        = 1'b1;
      bus.din_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         bus.din = W'(k);
         tick("fixed5");
         if (k == 4) begin
            cmp("pre5_dout",   32'(bus.dout),       32'd0);
            cmp("pre5_vld",    32'(bus.dout_valid), 32'd0);
            cmp("pre5_primed", 32'(bus.primed),     32'd0);
         end
         if (k == 5) begin
            cmp("edge5_dout",   32'(bus.dout),   32'd1);
            cmp("edge5_primed", 32'(bus.primed), 32'd1);
         end
         if (k == 6) cmp("edge6_dout", 32'(bus.dout), 32'd2);
      end

      // Clamping at both ends
      bus.delay = '0;
      bus.din   = W'(18'h1234);
      tick("clamp0");
      cmp("clamp0_lat1", 32'(bus.dout), 32'h1234);
      bus.delay = DW'(40);
      do_flush();
      for (int k = 1; k <= 34; k++) begin
         bus.din = W'($urandom);
         tick("clamp40");
         if (k == 31) cmp("clamp40_not_primed", 32'(bus.primed), 32'd0);
         if (k == 32) cmp("clamp40_primed",     32'(bus.primed), 32'd1);
      end

      // Enable gap at delay 3
      bus.delay = DW'(3);
      do_flush();
      bus.din = W'(18'hA);
      tick("gap_e1");
      bus.din = W'(18'hB);
      tick("gap_e2");
      bus.en = 1'b0;
      for (int k = 0; k < 4; k++) tick("gap_off");
      bus.en  = 1'b1;
      bus.din = W'(18'hC);
      tick("gap_e3");
      cmp("gap_dout_A", 32'(bus.dout), 32'hA);

      // Flush a full line at delay 8
      bus.delay = DW'(8);
      for (int k = 0; k < 40; k++) begin
         bus.din = W'($urandom);
         tick("fill8");
      end
      do_flush();
      cmp("flush_vld",    32'(bus.dout_valid), 32'd0);
      cmp("flush_primed", 32'(bus.primed),     32'd0);
      for (int k = 0; k < 8; k++) begin
         bus.din = W'($urandom);
         tick("refill8");
      end
      cmp("refill_vld",    32'(bus.dout_valid), 32'd1);
      cmp("refill_primed", 32'(bus.primed),     32'd1);

      // Delay changes take effect combinationally
      bus.delay = DW'(4);
      for (int k = 0; k < 10; k++) begin
         bus.din = W'($urandom);
         tick("d4");
      end
      bus.delay = DW'(2);
      #1 chk("d4to2");
      cmp("d4to2_primed", 32'(bus.primed), 32'd1);
      do_flush();
      bus.delay = DW'(4);
      for (int k = 0; k < 10; k++) begin
         bus.din = W'($urandom);
         tick("pre16");
      end
      bus.delay = DW'(16);
      #1 chk("to16");
      cmp("to16_primed", 32'(bus.primed), 32'd0);
      for (int k = 0; k < 8; k++) begin
         bus.din = W'($urandom);
         tick("to16_run");
         if (k == 4) cmp("fill15_primed", 32'(bus.primed), 32'd0);
         if (k == 5) cmp("fill16_primed", 32'(bus.primed), 32'd1);
      end

      // Async reset mid-stream, then a repeat of the first scenario
      cmp("pre_arst_vld", 32'(bus.dout_valid), 32'd1);
      async_reset();
      tick("in_reset");
      #1 rst_n = 1'b1;
      bus.delay = DW'(5);
      for (int k = 1; k <= 6; k++) begin
         bus.din = W'(k);
         tick("post_arst");
         if (k == 5) cmp("post_arst_dout", 32'(bus.dout), 32'd1);
      end

      // Random mix of enables, flushes, delays and occasional resets
      for (int k = 0; k < 600; k++) begin
         bus.en        = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 24) == 0);
         bus.din       = W'($urandom);
         bus.din_valid = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 15) == 0) begin
            bus.delay = DW'($urandom_range(0, (1 << DW) - 1));
            #1 chk("rnd_dchg");
         end
         if ($urandom_range(0, 149) == 0) begin
            async_reset();
            tick("rnd_in_reset");
            #1 rst_n = 1'b1;
         end
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/srl_var_delay.md
Name: srl_var_delay

Overview:
- Run-time programmable delay line with a valid-bit shadow pipeline.
- Successor to the fixed-length SRL: adds a selectable tap depth, reset, flush, per-word valid tracking and a fill/primed status.
- Used in datapaths that must align streams whose latency mismatch is set by configuration, not at synthesis time.

Parameters:
- SRL_WIDTH, 18, data word width in bits (≥1).
- SRL_MAX_DEPTH, 32, number of physical stages; maximum selectable delay (≥2).
- DW, $clog2(SRL_MAX_DEPTH+1), width of the delay-select port (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  shift enable. The array advances only when en=1.
- flush  in  1  synchronous clear of all valid bits and the fill counter.
- delay  in  DW  requested delay in en-cycles.
- din  in  SRL_WIDTH  input word.
- din_valid  in  1  qualifies din.
- dout  out  SRL_WIDTH  word at the selected tap.
- dout_valid  out  1  valid bit at the selected tap.
- primed  out  1  high once the line holds at least eff_delay shifted entries since the last reset or flush.

Behaviour:
- Effective delay: eff_delay = 1 if delay==0; SRL_MAX_DEPTH if delay>SRL_MAX_DEPTH; otherwise delay. Clamping is combinational.
- Storage: stage[0..SRL_MAX_DEPTH-1] of SRL_WIDTH bits, plus vld[0..SRL_MAX_DEPTH-1].
- On a clock edge with en=1 and flush=0:
  - stage[0]<=din, vld[0]<=din_valid.
  - stage[i+1]<=stage[i] and vld[i+1]<=vld[i] for all i.
- en=0: all state holds, including the fill counter.
- Output tap: dout=stage[eff_delay-1] and dout_valid=vld[eff_delay-1], both combinational from the tap mux.
  - A word presented with en=1 at edge k appears on dout after exactly eff_delay enabled edges. Disabled cycles do not count.
- Delay change: takes effect in the same cycle (mux only). No data is moved or dropped.
  - Increasing delay exposes older stage contents. Their vld bits are whatever was shifted in; if the line was flushed or reset, they are 0.
  - primed re-evaluates against the new eff_delay in the same cycle.
- Fill counter fill_cnt:
  - Range 0..SRL_MAX_DEPTH. Increments on every edge with en=1 and flush=0, then saturates at SRL_MAX_DEPTH.
  - primed = (fill_cnt >= eff_delay).
- flush=1 at an edge:
  - All vld<=0 and fill_cnt<=0. Data stages keep their contents; no shift occurs even if en=1.
  - flush overrides en.
  - dout_valid=0 and primed=0 from the next cycle until refilled.
- Reset (rst_n=0, asynchronous):
  - All stages<=0, all vld<=0, fill_cnt<=0.
  - Hence dout=0, dout_valid=0, primed=0 immediately, without waiting for a clock.
  - Release is synchronous to clk. The first shift occurs on the first rising edge with rst_n=1 and en=1.
  - Reset mid-stream discards all in-flight words.
- Simultaneous events:
  - rst_n low dominates all inputs.
  - flush dominates en.
  - A delay change coincident with a shift: the new tap applies to post-edge contents.
- No backpressure: data falling off stage[SRL_MAX_DEPTH-1] is discarded silently.

Test Plan:
- Reset then fixed delay:
  - Stimulus: rst_n pulse; delay=5; en=1; din=1,2,3… with din_valid=1.
  - Required: dout=0 and dout_valid=0 before the 5th edge. dout=1 after edge 5, dout=2 after edge 6. primed rises after edge 5.
- Clamping:
  - delay=0 → dout follows din with 1-cycle latency.
  - delay=40 with SRL_MAX_DEPTH=32 → latency 32. primed asserts only after 32 enabled edges.
- Enable gaps:
  - Stimulus: delay=3; din=0xA at edge 1; en=0 for 4 cycles after edge 2.
  - Required: dout and fill_cnt frozen during the gap. 0xA appears after the 3rd enabled edge (real edge 7).
- Flush:
  - Stimulus: line full at delay=8; assert flush with en=1 for one edge.
  - Required: next cycle dout_valid=0, primed=0, no shift. After 8 further enabled edges of valid input, dout_valid=1 and primed=1.
- Delay change:
  - Stimulus: steady stream at delay=4; switch to delay=2.
  - Required: dout jumps to the word 2 cycles old in the same cycle; primed stays 1.
  - Stimulus: switch to delay=16 when fill_cnt=10.
  - Required: primed=0 until fill_cnt reaches 16.
- Async reset mid-operation:
  - Stimulus: drop rst_n between clock edges while dout_valid=1.
  - Required: dout=0, dout_valid=0, primed=0 before the next edge. After release, behaviour is as in the first scenario.
